// File: rtl/ysyx_pkg.sv
// Shared RV32I decode definitions: opcode constants, the 4-bit opcode class
// enum, SYSTEM funct3 constants and an opcode-to-class helper used by both
// the decode stage and the immediate generator.
package ysyx_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // CLS_LUI is encoding 0, which is also the post-reset value of the bundle.
    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OP_IMM  = 4'd7,
        CLS_OP      = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd11
    } op_class_e;

    // Full 7-bit compare, so a non-11 low pair always lands in CLS_ILLEGAL.
    function automatic op_class_e opcode_class(input logic [6:0] opc);
        case (opc)
            OPC_LUI:    return CLS_LUI;
            OPC_AUIPC:  return CLS_AUIPC;
            OPC_JAL:    return CLS_JAL;
            OPC_JALR:   return CLS_JALR;
            OPC_BRANCH: return CLS_BRANCH;
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_OP_IMM: return CLS_OP_IMM;
            OPC_OP:     return CLS_OP;
            OPC_FENCE:  return CLS_FENCE;
            OPC_SYSTEM: return CLS_SYSTEM;
            default:    return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_idu_if.sv
// Fetch -> decode -> execute signal bundle.
// slave  : the decode stage (consumes prev_valid/inst/pc/flush/next_ready,
//          drives ready_o and the registered decoded bundle).
// master : the surrounding pipeline / testbench side.
interface ysyx_idu_if
    import ysyx_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              prev_valid;
    logic              ready_o;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              next_ready;
    logic              valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic [DATA_W-1:0] inst_o;
    op_class_e         op_class_o;
    logic [4:0]        rd_o;
    logic [4:0]        rs1_o;
    logic [4:0]        rs2_o;
    logic [2:0]        funct3_o;
    logic              funct7b5_o;
    logic [DATA_W-1:0] imm_o;
    logic              rd_we_o;
    logic              illegal_o;
    logic              ecall_o;
    logic              ebreak_o;

    modport slave (
        input  prev_valid, inst, pc, flush, next_ready,
        output ready_o, valid_o, pc_o, inst_o, op_class_o, rd_o, rs1_o, rs2_o,
               funct3_o, funct7b5_o, imm_o, rd_we_o, illegal_o, ecall_o, ebreak_o
    );

    modport master (
        output prev_valid, inst, pc, flush, next_ready,
        input  ready_o, valid_o, pc_o, inst_o, op_class_o, rd_o, rs1_o, rs2_o,
               funct3_o, funct7b5_o, imm_o, rd_we_o, illegal_o, ecall_o, ebreak_o
    );
endinterface

// File: rtl/ysyx_idu_imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J format from
// the opcode and returns the sign-extended immediate (0 for R-type and
// unrecognised opcodes). Shared with the fetch branch-target logic.
// Ports: inst (in, 32) instruction word; imm (out, 32) immediate.
module ysyx_idu_imm_gen
    import ysyx_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);
    always_comb begin
        imm = 32'd0;
        case (opcode_class(inst[6:0]))
            CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_FENCE, CLS_SYSTEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            CLS_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            CLS_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                imm = {inst[31:12], 12'd0};
            CLS_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end
endmodule

// File: rtl/ysyx_idu.sv
// RV32I instruction decode stage. Single-entry registered output bundle with
// valid/ready handshakes on both sides and a one-cycle flush.
// Ports: clk, rst (sync, active-high); bus (ysyx_idu_if.slave) carrying the
// fetch handshake (prev_valid/ready_o/inst/pc), flush, the execute handshake
// (valid_o/next_ready) and the decoded fields.
module ysyx_idu
    import ysyx_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    ysyx_idu_if.slave  bus
);
    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] inst_q;
    op_class_e         cls_q;
    logic [DATA_W-1:0] imm_q;
    logic              rd_we_q;
    logic              ecall_q;
    logic              ebreak_q;

    logic              accept;
    logic              handoff;
    op_class_e         d_cls;
    logic [31:0]       d_imm;
    logic              d_rd_we;
    logic              d_ecall;
    logic              d_ebreak;
    logic [2:0]        d_f3;

    // Pass-through ready keeps one instruction per cycle under continuous flow.
    assign bus.ready_o = !valid_q || bus.next_ready;
    assign accept      = bus.prev_valid && bus.ready_o && !bus.flush;
    assign handoff     = valid_q && bus.next_ready;

    ysyx_idu_imm_gen u_imm_gen (
        .inst (bus.inst[31:0]),
        .imm  (d_imm)
    );

    always_comb begin
        d_cls    = opcode_class(bus.inst[6:0]);
        d_f3     = bus.inst[14:12];
        d_rd_we  = 1'b0;
        d_ecall  = 1'b0;
        d_ebreak = 1'b0;
        case (d_cls)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_OP:
                d_rd_we = 1'b1;
            CLS_SYSTEM: begin
                d_rd_we  = (d_f3 != F3_PRIV);
                d_ecall  = (d_f3 == F3_PRIV) && !bus.inst[20];
                d_ebreak = (d_f3 == F3_PRIV) &&  bus.inst[20];
            end
            default: d_rd_we = 1'b0;
        endcase
        if (bus.inst[11:7] == 5'd0) d_rd_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            cls_q    <= CLS_LUI;
            imm_q    <= '0;
            rd_we_q  <= 1'b0;
            ecall_q  <= 1'b0;
            ebreak_q <= 1'b0;
        end else begin
            if (bus.flush)   valid_q <= 1'b0;
            else if (accept) valid_q <= 1'b1;
            else if (handoff) valid_q <= 1'b0;

            if (accept) begin
                pc_q     <= bus.pc;
                inst_q   <= bus.inst;
                cls_q    <= d_cls;
                imm_q    <= DATA_W'(d_imm);
                rd_we_q  <= d_rd_we;
                ecall_q  <= d_ecall;
                ebreak_q <= d_ebreak;
            end
        end
    end

    // Register fields are sliced from the held raw instruction.
    assign bus.valid_o    = valid_q;
    assign bus.pc_o       = pc_q;
    assign bus.inst_o     = inst_q;
    assign bus.op_class_o = cls_q;
    assign bus.rd_o       = inst_q[11:7];
    assign bus.rs1_o      = inst_q[19:15];
    assign bus.rs2_o      = inst_q[24:20];
    assign bus.funct3_o   = inst_q[14:12];
    assign bus.funct7b5_o = inst_q[30];
    assign bus.imm_o      = imm_q;
    assign bus.rd_we_o    = rd_we_q;
    assign bus.illegal_o  = (cls_q == CLS_ILLEGAL);
    assign bus.ecall_o    = ecall_q;
    assign bus.ebreak_o   = ebreak_q;
endmodule

// File: tb/tb_ysyx_idu.sv
// Directed self-checking bench for ysyx_idu.
module tb_ysyx_idu;
    import ysyx_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    ysyx_idu_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    ysyx_idu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] i, input logic [31:0] p);
        bus_if.prev_valid = pv;
        bus_if.inst       = i;
        bus_if.pc         = p;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus_if.flush      = 1'b0;
        bus_if.next_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // reset
        step();
        chk("ready_in_reset", 32'(bus_if.ready_o), 32'd1);
        step();
        chk("rst_valid", 32'(bus_if.valid_o), 32'd0);
        chk("rst_pc", bus_if.pc_o, 32'h0);
        chk("rst_imm", bus_if.imm_o, 32'h0);
        rst = 1'b0;

        // addi x1,x0,5
        drive(1'b1, 32'h00500093, 32'h80000000);
        step();
        chk("addi_valid", 32'(bus_if.valid_o), 32'd1);
        chk("addi_cls", 32'(bus_if.op_class_o), 32'(CLS_OP_IMM));
        chk("addi_rd", 32'(bus_if.rd_o), 32'd1);
        chk("addi_rs1", 32'(bus_if.rs1_o), 32'd0);
        chk("addi_imm", bus_if.imm_o, 32'h00000005);
        chk("addi_we", 32'(bus_if.rd_we_o), 32'd1);
        chk("addi_pc", bus_if.pc_o, 32'h80000000);

        // sw x1,12(x2) back-to-back
        drive(1'b1, 32'h00112623, 32'h80000004);
        step();
        chk("sw_valid", 32'(bus_if.valid_o), 32'd1);
        chk("sw_cls", 32'(bus_if.op_class_o), 32'(CLS_STORE));
        chk("sw_rs1", 32'(bus_if.rs1_o), 32'd2);
        chk("sw_rs2", 32'(bus_if.rs2_o), 32'd1);
        chk("sw_imm", bus_if.imm_o, 32'h0000000C);
        chk("sw_we", 32'(bus_if.rd_we_o), 32'd0);

        // beq x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 32'h80000008);
        step();
        chk("beq_cls", 32'(bus_if.op_class_o), 32'(CLS_BRANCH));
        chk("beq_imm", bus_if.imm_o, 32'hFFFFFFFC);
        chk("beq_we", 32'(bus_if.rd_we_o), 32'd0);

        // lui x5,0x12345
        drive(1'b1, 32'h123452B7, 32'h8000000C);
        step();
        chk("lui_cls", 32'(bus_if.op_class_o), 32'(CLS_LUI));
        chk("lui_rd", 32'(bus_if.rd_o), 32'd5);
        chk("lui_imm", bus_if.imm_o, 32'h12345000);
        chk("lui_we", 32'(bus_if.rd_we_o), 32'd1);

        // stall 3 cycles with addi x2,x0,7 waiting upstream
        drive(1'b1, 32'h00700113, 32'h80000010);
        bus_if.next_ready = 1'b0;
        #1;
        chk("stall_ready", 32'(bus_if.ready_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", 32'(bus_if.valid_o), 32'd1);
            chk("stall_pc", bus_if.pc_o, 32'h8000000C);
            chk("stall_inst", bus_if.inst_o, 32'h123452B7);
            chk("stall_ready_hold", 32'(bus_if.ready_o), 32'd0);
        end
        bus_if.next_ready = 1'b1;
        #1;
        chk("release_ready", 32'(bus_if.ready_o), 32'd1);
        step();
        chk("release_inst", bus_if.inst_o, 32'h00700113);
        chk("release_pc", bus_if.pc_o, 32'h80000010);
        chk("release_rd", 32'(bus_if.rd_o), 32'd2);
        chk("release_imm", bus_if.imm_o, 32'h00000007);

        // flush with held bundle and incoming instruction
        drive(1'b1, 32'h00100073, 32'h80000014);
        bus_if.flush = 1'b1;
        #1;
        chk("flush_ready", 32'(bus_if.ready_o), 32'd1);
        step();
        chk("flush_valid", 32'(bus_if.valid_o), 32'd0);
        bus_if.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("flush_nothing", 32'(bus_if.valid_o), 32'd0);

        // illegal all-zero word
        drive(1'b1, 32'h00000000, 32'h80000018);
        step();
        chk("ill_valid", 32'(bus_if.valid_o), 32'd1);
        chk("ill_flag", 32'(bus_if.illegal_o), 32'd1);
        chk("ill_we", 32'(bus_if.rd_we_o), 32'd0);

        // ebreak
        drive(1'b1, 32'h00100073, 32'h8000001C);
        step();
        chk("ebreak_flag", 32'(bus_if.ebreak_o), 32'd1);
        chk("ebreak_ecall", 32'(bus_if.ecall_o), 32'd0);
        chk("ebreak_ill", 32'(bus_if.illegal_o), 32'd0);

        // ecall
        drive(1'b1, 32'h00000073, 32'h80000020);
        step();
        chk("ecall_flag", 32'(bus_if.ecall_o), 32'd1);
        chk("ecall_ebreak", 32'(bus_if.ebreak_o), 32'd0);
        chk("ecall_we", 32'(bus_if.rd_we_o), 32'd0);

        // csrrw x2,mscratch,x2 writes rd
        drive(1'b1, 32'h34011173, 32'h80000024);
        step();
        chk("csr_cls", 32'(bus_if.op_class_o), 32'(CLS_SYSTEM));
        chk("csr_we", 32'(bus_if.rd_we_o), 32'd1);
        chk("csr_f3", 32'(bus_if.funct3_o), 32'd1);

        // reset mid-stall
        drive(1'b1, 32'h00500093, 32'h80000028);
        step();
        bus_if.next_ready = 1'b0;
        drive(1'b1, 32'h00112623, 32'h8000002C);
        step();
        chk("pre_rst_pc", bus_if.pc_o, 32'h80000028);
        rst = 1'b1;
        step();
        chk("mrst_valid", 32'(bus_if.valid_o), 32'd0);
        chk("mrst_pc", bus_if.pc_o, 32'h0);
        chk("mrst_inst", bus_if.inst_o, 32'h0);
        chk("mrst_imm", bus_if.imm_o, 32'h0);
        chk("mrst_rd", 32'(bus_if.rd_o), 32'd0);
        chk("mrst_we", 32'(bus_if.rd_we_o), 32'd0);
        chk("mrst_ready", 32'(bus_if.ready_o), 32'd1);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("post_rst_valid", 32'(bus_if.valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
